// File: rtl/serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder_ctrl_if
// Brief   : Request/response handshake bundle for the nibble-serial adder.
// Revision: 1.0 - initial release
// ============================================================================
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder_ctrl (+ rca_adder_4bit)
// Brief   : Adds two WIDTH-bit operands one nibble per clock through a single
//           shared 4-bit ripple-carry adder, with valid/ready on both sides.
// Revision: 1.0 - initial release
// ============================================================================
module rca_adder_4bit (
    input  wire logic [3:0] i_a,
    input  wire logic [3:0] i_b,
    input  wire logic       i_cin,
    output logic      [3:0] o_sum,
    output logic            o_cout
);
    logic [4:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar gi = 0; gi < 4; gi++) begin : g_bit
        assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
        assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
    end

    assign o_cout = w_c[4];
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    serial_adder_ctrl_if.slave bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDXW    = $clog2(NIBBLES);
    localparam logic [IDXW-1:0] c_last_idx = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_accept;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_last;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [IDXW-1:0]  r_idx;

    logic [IDXW+1:0]  w_bit_base;
    logic [3:0]       w_nib_a;
    logic [3:0]       w_nib_b;
    logic [3:0]       w_nib_sum;
    logic             w_nib_cout;

    assign w_last = (r_idx == c_last_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Bit offset of the current nibble: idx * 4.
    assign w_bit_base = {r_idx, 2'b00};
    assign w_nib_a    = r_a[w_bit_base +: 4];
    assign w_nib_b    = r_b[w_bit_base +: 4];

    rca_adder_4bit u_adder (
        .i_a    (w_nib_a),
        .i_b    (w_nib_b),
        .i_cin  (r_carry),
        .o_sum  (w_nib_sum),
        .o_cout (w_nib_cout)
    );

    // Carry between nibbles lives in r_carry; cout is only updated on the
    // final nibble and otherwise keeps the previous result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_sum   <= '0;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            r_sum[w_bit_base +: 4] <= w_nib_sum;
            r_carry                <= w_nib_cout;
            if (w_last) begin
                r_cout <= w_nib_cout;
            end else begin
                r_idx <= r_idx + IDXW'(1);
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_adder_ctrl
// Brief   : Self-checking bench for serial_adder_ctrl against a + b + cin.
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;
    localparam int WIDTH   = 16;
    localparam int LATENCY = WIDTH / 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic ci);
        int unsigned r;
        r = int'(x) + int'(y) + int'(ci);
        return r[WIDTH:0];
    endfunction

    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tc, input int hold);
        int             w;
        int             lat;
        logic [WIDTH:0] exp;
        bus.a         = ta;
        bus.b         = tb;
        bus.cin       = tc;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            tick();
            w++;
        end
        check("accept_ready", 32'(bus.in_ready), 32'd1);
        exp = model(ta, tb, tc);
        tick();
        bus.in_valid = 1'b0;
        bus.a        = WIDTH'($urandom);
        bus.b        = WIDTH'($urandom);
        bus.cin      = 1'($urandom);
        check("busy_run", 32'(bus.busy), 32'd1);
        check("in_ready_run", 32'(bus.in_ready), 32'd0);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'(LATENCY));
        check("sum", 32'(bus.sum), 32'(exp[WIDTH-1:0]));
        check("cout", 32'(bus.cout), 32'(exp[WIDTH]));
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.a        = WIDTH'($urandom);
            bus.b        = WIDTH'($urandom);
            tick();
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("hold_sum", 32'(bus.sum), 32'(exp[WIDTH-1:0]));
            check("hold_cout", 32'(bus.cout), 32'(exp[WIDTH]));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("release_valid", 32'(bus.out_valid), 32'd0);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
        check("release_busy", 32'(bus.busy), 32'd0);
        check("retained_sum", 32'(bus.sum), 32'(exp[WIDTH-1:0]));
        check("retained_cout", 32'(bus.cout), 32'(exp[WIDTH]));
    endtask

    logic [WIDTH:0] exp_q[$];
    int             acc_cyc[$];

    initial begin
        int             cyc;
        int             n_acc;
        int             n_res;
        logic [WIDTH:0] e;

        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = 16'hBEEF;
        bus.b         = 16'hCAFE;
        bus.cin       = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        tick();
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_sum", 32'(bus.sum), 32'd0);
        check("reset_cout", 32'(bus.cout), 32'd0);

        run_op(16'h1234, 16'h4321, 1'b0, 5);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 1);
        run_op(16'h8000, 16'h8000, 1'b0, 0);

        // Abort an operation after two RUN cycles.
        bus.a        = 16'hFFFF;
        bus.b        = 16'hFFFF;
        bus.cin      = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_sum", 32'(bus.sum), 32'd0);
        check("midrst_cout", 32'(bus.cout), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        run_op(16'h0F0F, 16'h00F1, 1'b0, 0);

        for (int k = 0; k < 20; k++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)));
        end

        // Streaming: in_valid and out_ready held high.
        bus.a         = WIDTH'($urandom);
        bus.b         = WIDTH'($urandom);
        bus.cin       = 1'($urandom);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        cyc   = 0;
        n_acc = 0;
        n_res = 0;
        while (n_res < 3 && cyc < 60) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("stream_spurious", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_sum", 32'(bus.sum), 32'(e[WIDTH-1:0]));
                    check("stream_cout", 32'(bus.cout), 32'(e[WIDTH]));
                end
                n_res++;
            end
            if (bus.in_ready && bus.in_valid) begin
                exp_q.push_back(model(bus.a, bus.b, bus.cin));
                acc_cyc.push_back(cyc);
                n_acc++;
            end
            tick();
            cyc++;
            if (n_acc >= 3) bus.in_valid = 1'b0;
            bus.a   = WIDTH'($urandom);
            bus.b   = WIDTH'($urandom);
            bus.cin = 1'($urandom);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("stream_results", 32'(n_res), 32'd3);
        if (acc_cyc.size() == 3) begin
            check("stream_gap0", 32'(acc_cyc[1] - acc_cyc[0]), 32'(LATENCY + 2));
            check("stream_gap1", 32'(acc_cyc[2] - acc_cyc[1]), 32'(LATENCY + 2));
        end else begin
            check("stream_accepts", 32'(acc_cyc.size()), 32'd3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Sequencer that adds two WIDTH-bit operands using one shared rca_adder_4bit instance. It processes one nibble per clock, least-significant nibble first, and holds the carry in a register between steps. It sits between a requester and a consumer, with a valid/ready handshake on each side. It trades latency for area when a wide adder is needed.

Parameters:
- WIDTH, 16, operand/result width. Must be a multiple of 4 and ≥ 8.
- NIBBLES, WIDTH/4, derived localparam, not overridable. Number of adder steps per operation.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, requester presents an operation.
- in_ready, output, 1, block can accept an operation.
- a, input, WIDTH, operand A. Sampled only on accept.
- b, input, WIDTH, operand B. Sampled only on accept.
- cin, input, 1, carry-in. Sampled only on accept.
- out_valid, output, 1, result available.
- out_ready, input, 1, consumer takes the result.
- sum, output, WIDTH, registered result.
- cout, output, 1, registered carry-out of the MSB nibble.
- busy, output, 1, high whenever state is not IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state to IDLE; nibble index to 0; carry register to 0.
  - Operand registers, sum and cout to 0.
  - out_valid=0, busy=0, in_ready=1 after the edge.
  - Reset wins over every other event, including in_valid=1 or mid-RUN; any in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept = in_valid & in_ready at a clk edge.
  - On accept: latch a, b, cin; clear the sum register; set idx=0; go to RUN.
- RUN:
  - in_ready=0.
  - The shared adder takes a_reg[4*idx+3:4*idx], b_reg[same slice], and the carry register as cin.
  - At each edge: write the adder sum into sum[4*idx+3:4*idx] and load the adder cout into the carry register.
  - If idx==NIBBLES-1: load cout from the adder cout and go to DONE. Otherwise idx++.
  - Exactly NIBBLES cycles are spent in RUN.
- DONE:
  - out_valid=1; sum and cout are stable and hold while out_ready=0, for any number of cycles.
  - When out_ready=1 at an edge, go to IDLE and drop out_valid.
  - in_ready=0 in DONE; in_valid is ignored.
- Latency: out_valid rises NIBBLES clk edges after the accept edge (4 for WIDTH=16).
- Throughput: with out_ready tied high and in_valid held high, one operation per NIBBLES+2 cycles (RUN×NIBBLES, DONE×1, IDLE×1).
- Arithmetic:
  - Result is {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
  - Operands are unsigned; overflow is signalled only through cout.
  - The carry must ripple across nibble boundaries through the carry register, not be recomputed.
- Operand inputs changing while busy have no effect on the operation in progress.
- sum and cout keep their last result after DONE→IDLE, until the next accept clears sum.
- Exactly one rca_adder_4bit instance; no other adder logic.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0 → sum=0x5555, cout=0; out_valid high exactly 4 edges after accept.
- a=0xFFFF, b=0x0001, cin=0 → carry ripples through all nibbles; sum=0x0000, cout=1.
- a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1. Also a=0x8000, b=0x8000, cin=0 → sum=0x0000, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands → sum/cout unchanged, in_ready=0, new operands not taken. Release out_ready → IDLE next edge, then accept the new operation.
- Reset mid-RUN: assert rst after 2 RUN cycles → next edge gives IDLE, out_valid=0, sum=0, cout=0, in_ready=1. The following operation 0x0F0F+0x00F1 gives sum=0x1000, cout=0.
- Streaming: in_valid held high, out_ready=1, three operations back-to-back → accepts spaced 6 cycles apart, with results in order and correct.
